// File: rtl/iic_slave_regs.sv
// I2C write-only target for codec-style {dev, reg/d8, data} frames backed by a 9-bit register file.
// States: IDLE bus free | DEV_ADDR collect address | DEV_ACK/ACK1/ACK2 drive ACK | BYTE1/BYTE2 collect | IGNORE wait START/STOP
module iic_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 16,
    parameter int         FILT_LEN = 4
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       iic_sclk,
    input  logic       iic_sda_in,
    output logic       iic_sda_oe,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int FW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, DEV_ADDR_S, DEV_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA; idle bus level is high
    logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
    logic [FW-1:0] fcnt_q [2];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            filt_q    <= '1;
            prev_q    <= '1;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync1_q <= {iic_sda_in, iic_sclk};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] &  prev_q[0];
    assign start_det =  filt_q[0] &  prev_q[0] &  prev_q[1] & ~filt_q[1];
    assign stop_det  =  filt_q[0] &  prev_q[0] & ~prev_q[1] &  filt_q[1];

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       full_q;
    logic [6:0] reg_addr_q;
    logic       d8_q;
    logic       sda_oe_q, wr_stb_q, busy_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [8:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            full_q     <= 1'b0;
            reg_addr_q <= '0;
            d8_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            if (start_det) begin
                state_q   <= DEV_ADDR_S;
                bit_cnt_q <= '0;
                full_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b1;
            end else if (stop_det) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                full_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    DEV_ADDR_S, BYTE1, BYTE2: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], filt_q[1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) full_q <= 1'b1;
                        end else if (scl_fall && full_q) begin
                            full_q <= 1'b0;
                            case (state_q)
                                DEV_ADDR_S: begin
                                    if (shift_q == {DEV_ADDR, 1'b0}) begin
                                        sda_oe_q <= 1'b1;
                                        state_q  <= DEV_ACK;
                                    end else begin
                                        state_q  <= IGNORE;
                                    end
                                end
                                BYTE1: begin
                                    reg_addr_q <= shift_q[7:1];
                                    d8_q       <= shift_q[0];
                                    if ({25'd0, shift_q[7:1]} < NUM_REGS) begin
                                        sda_oe_q <= 1'b1;
                                        state_q  <= ACK1;
                                    end else begin
                                        state_q  <= IGNORE;
                                    end
                                end
                                default: begin
                                    regs_q[reg_addr_q[AW-1:0]] <= {d8_q, shift_q};
                                    wr_addr_q <= reg_addr_q;
                                    wr_data_q <= {d8_q, shift_q};
                                    wr_stb_q  <= 1'b1;
                                    sda_oe_q  <= 1'b1;
                                    state_q   <= ACK2;
                                end
                            endcase
                        end
                    end
                    // the first SCL fall seen in an ACK state ends the ACK clock
                    DEV_ACK, ACK1, ACK2: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            full_q    <= 1'b0;
                            state_q   <= (state_q == ACK1) ? BYTE2 : BYTE1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if ({25'd0, rd_addr} < NUM_REGS) rd_data = regs_q[rd_addr[AW-1:0]];
    end

    assign iic_sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: drives I2C frames from a table, scoreboards write strobes, checks ACKs and register contents.
module tb_iic_slave_regs;

    localparam int Q = 15;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       scl, sda_drv;
    logic       iic_sda_in, iic_sda_oe, wr_stb, busy;
    logic [6:0] wr_addr, rd_addr;
    logic [8:0] wr_data, rd_data;

    assign iic_sda_in = sda_drv & ~iic_sda_oe;

    iic_slave_regs dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .iic_sclk   (scl),
        .iic_sda_in (iic_sda_in),
        .iic_sda_oe (iic_sda_oe),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [6:0] a;
        logic [8:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] dev, b1, b2;
        logic       a0, a1, a2;
    } frame_t;

    int         errors = 0;
    int         checks = 0;
    int         stb_count = 0;
    logic       oe_seen = 1'b0;
    wr_t        exp_q [$];
    logic [8:0] mregs [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk_50m) begin
        #1;
        if (iic_sda_oe === 1'b1) oe_seen = 1'b1;
        if (wr_stb === 1'b1) begin
            wr_t e;
            stb_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_stb_unexpected: got addr 0x%0h data 0x%0h expected no strobe", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    errors++;
                    $display("FAIL wr_event: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic i2c_start();
        wclk(Q); sda_drv = 1'b1;
        wclk(Q); scl = 1'b1;
        wclk(Q); sda_drv = 1'b0;
        wclk(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(Q); sda_drv = 1'b0;
        wclk(Q); scl = 1'b1;
        wclk(Q); sda_drv = 1'b1;
        wclk(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            wclk(Q); sda_drv = b[i];
            wclk(Q); scl = 1'b1;
            wclk(2 * Q); scl = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        send_bits(b, 8);
        wclk(Q); sda_drv = 1'b1;
        wclk(Q); scl = 1'b1;
        wclk(Q); check(nm, iic_sda_oe, exp_ack);
        wclk(Q); scl = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] b1, input logic [7:0] b2);
        wr_t e;
        e.a = b1[7:1];
        e.d = {b1[0], b2};
        exp_q.push_back(e);
        mregs[e.a[3:0]] = e.d;
    endtask

    task automatic send_frame(input frame_t f, input int idx);
        i2c_start();
        check($sformatf("busy_start[%0d]", idx), busy, 1);
        send_byte(f.dev, f.a0, $sformatf("ack_dev[%0d]", idx));
        send_byte(f.b1, f.a1, $sformatf("ack_b1[%0d]", idx));
        if (f.a0 && f.a1 && f.a2) expect_write(f.b1, f.b2);
        send_byte(f.b2, f.a2, $sformatf("ack_b2[%0d]", idx));
        i2c_stop();
        check($sformatf("busy_stop[%0d]", idx), busy, 0);
    endtask

    task automatic check_reg(input int idx, input logic [8:0] exp);
        rd_addr = 7'(idx);
        #2;
        check($sformatf("rd_data[%0d]", idx), rd_data, exp);
    endtask

    frame_t tbl [$];
    int     stb_before;
    logic [8:0] codec_exp [10];

    initial begin
        tbl.push_back('{8'h34, 8'h00, 8'h1F, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h00, 8'h1F, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h02, 8'h1F, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h04, 8'h79, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h06, 8'h79, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h08, 8'hF8, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h0A, 8'h06, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h0C, 8'h00, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h0E, 8'h01, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h10, 8'h02, 1, 1, 1});
        tbl.push_back('{8'h34, 8'h12, 8'h01, 1, 1, 1});
        tbl.push_back('{8'h36, 8'h00, 8'h55, 0, 0, 0});
        tbl.push_back('{8'h35, 8'h02, 8'hAA, 0, 0, 0});
        tbl.push_back('{8'h34, 8'h20, 8'h55, 1, 0, 0});
        codec_exp = '{9'h01F, 9'h01F, 9'h079, 9'h079, 9'h0F8, 9'h006, 9'h000, 9'h001, 9'h002, 9'h001};
        for (int i = 0; i < 16; i++) mregs[i] = '0;

        rst = 1'b1; scl = 1'b1; sda_drv = 1'b1; rd_addr = '0;
        wclk(5);
        rst = 1'b0;
        wclk(5);
        check("rst_oe", iic_sda_oe, 0);
        check("rst_stb", wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check_reg(0, 9'h000);

        send_frame(tbl[0], 0);
        check_reg(0, 9'h01F);
        check("hold_wr_addr", wr_addr, 7'h00);
        check("hold_wr_data", wr_data, 9'h01F);

        stb_before = stb_count;
        for (int i = 1; i <= 10; i++) send_frame(tbl[i], i);
        check("codec_stb_count", stb_count - stb_before, 10);
        for (int i = 0; i < 10; i++) check_reg(i, codec_exp[i]);
        check_reg(16, 9'h000);
        check_reg(127, 9'h000);

        stb_before = stb_count;
        oe_seen = 1'b0;
        send_frame(tbl[11], 11);
        send_frame(tbl[12], 12);
        check("nack_oe_seen", oe_seen, 0);
        send_frame(tbl[13], 13);
        check("nack_stb_count", stb_count - stb_before, 0);
        for (int i = 0; i < 16; i++) check_reg(i, mregs[i]);

        // truncated frames: STOP after byte1, then repeated START mid-byte2
        stb_before = stb_count;
        i2c_start();
        send_byte(8'h34, 1, "trunc_a_dev");
        send_byte(8'h02, 1, "trunc_a_b1");
        i2c_stop();
        i2c_start();
        send_byte(8'h34, 1, "trunc_b_dev");
        send_byte(8'h02, 1, "trunc_b_b1");
        send_bits(8'h55, 3);
        i2c_start();
        send_byte(8'h34, 1, "trunc_c_dev");
        send_byte(8'h04, 1, "trunc_c_b1");
        expect_write(8'h04, 8'h79);
        send_byte(8'h79, 1, "trunc_c_b2");
        i2c_stop();
        check("trunc_stb_count", stb_count - stb_before, 1);
        check_reg(1, 9'h01F);
        check_reg(2, 9'h079);

        // two {reg,data} pairs in one transaction
        stb_before = stb_count;
        i2c_start();
        send_byte(8'h34, 1, "b2b_dev");
        send_byte(8'h0C, 1, "b2b_b1a");
        expect_write(8'h0C, 8'h00);
        send_byte(8'h00, 1, "b2b_b2a");
        send_byte(8'h0E, 1, "b2b_b1b");
        expect_write(8'h0E, 8'h01);
        send_byte(8'h01, 1, "b2b_b2b");
        i2c_stop();
        check("b2b_stb_count", stb_count - stb_before, 2);
        check_reg(6, 9'h000);
        check_reg(7, 9'h001);
        check("b2b_wr_addr", wr_addr, 7'h07);
        check("b2b_wr_data", wr_data, 9'h001);

        // reset in the middle of byte2
        i2c_start();
        send_byte(8'h34, 1, "rstb2_dev");
        send_byte(8'h0C, 1, "rstb2_b1");
        send_bits(8'h55, 4);
        #5 rst = 1'b1;
        #1;
        check("rstb2_oe", iic_sda_oe, 0);
        check("rstb2_busy", busy, 0);
        check("rstb2_wr_addr", wr_addr, 0);
        check("rstb2_wr_data", wr_data, 0);
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        for (int i = 0; i < 16; i++) check_reg(i, mregs[i]);
        scl = 1'b1; sda_drv = 1'b1;
        wclk(5);
        rst = 1'b0;
        wclk(20);

        // reset while the address ACK is being driven releases SDA without a clock edge
        i2c_start();
        send_bits(8'h34, 8);
        wclk(Q); sda_drv = 1'b1;
        wclk(Q); scl = 1'b1;
        wclk(Q);
        check("hold_ack_oe", iic_sda_oe, 1);
        #5 rst = 1'b1;
        #1;
        check("async_rst_oe", iic_sda_oe, 0);
        scl = 1'b1; sda_drv = 1'b1;
        wclk(5);
        rst = 1'b0;
        wclk(20);
        check("post_rst_busy", busy, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
I2C target (responder) that accepts codec-style 3-byte register writes: device address byte, then {reg_addr[6:0], data[8]}, then data[7:0]. It stores the 9-bit values in an internal register file and exposes a write strobe and a read port to the fabric. It is the bus-side counterpart of our I2C codec configuration master. We use it for loopback verification of the config sequencer and as a soft codec-register model in the FPGA.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address (write byte 0x34).
NUM_REGS, 16, register file depth; legal reg_addr range is 0..NUM_REGS-1.
FILT_LEN, 4, number of consecutive equal clk_50m samples required to accept a new SCL/SDA level.

Ports:
clk_50m  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
iic_sclk  input  1  I2C SCL from the bus
iic_sda_in  input  1  I2C SDA sampled from the bus
iic_sda_oe  output  1  1 = pull SDA low (ACK); 0 = release the line (open drain)
wr_stb  output  1  one-cycle pulse when a register is written
wr_addr  output  7  register address of the last write
wr_data  output  9  data of the last write
rd_addr  input  7  fabric read address
rd_data  output  9  combinational read of regfile[rd_addr]; 0 when rd_addr >= NUM_REGS
busy  output  1  high from an accepted START until STOP or return to IDLE

Behaviour:
- Reset (async, rst=1): iic_sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, all regfile entries=0, FSM=IDLE. Reset mid-frame aborts the frame without a write, and the line is released immediately.
- Input conditioning: 2-FF synchronizer on SCL and SDA, then a FILT_LEN-sample glitch filter. Edge detects use the filtered signals only.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are legal in any state. A START always goes to DEV_ADDR with the bit counter cleared. A STOP always goes to IDLE. Neither one writes to the regfile.
- Data bits are sampled on the SCL rising edge, MSB first, into an 8-bit shift register with a 3-bit counter.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
- DEV_ADDR: collect 8 bits. On the SCL falling edge after bit 8:
  - {addr[6:0]} == DEV_ADDR and R/W = 0: assert iic_sda_oe, go to DEV_ACK.
  - Otherwise: keep iic_sda_oe=0 (NACK) and go to IGNORE. Read requests are NACKed.
- ACK states: iic_sda_oe holds for exactly one SCL low-high-low period. It is released on the next SCL falling edge, then the FSM enters the next byte state.
- BYTE1: on completion, latch reg_addr = byte[7:1] and d8 = byte[0].
  - reg_addr < NUM_REGS: ACK, go to ACK1.
  - Otherwise: NACK, go to IGNORE.
- BYTE2: on completion, ACK and go to ACK2. In the same clk_50m cycle as the SCL falling edge that starts the ACK, do all of the following:
  - write regfile[reg_addr] = {d8, byte}
  - set wr_addr/wr_data
  - pulse wr_stb for 1 cycle
- After ACK2 the FSM returns to BYTE1, so further {reg,data} pairs in the same transaction are accepted. Each pair is written independently and there is no auto-increment.
- IGNORE: iic_sda_oe=0 and no writes. Leave only on START or STOP.
- A frame truncated before the ACK2 edge (STOP or repeated START after byte1 or mid-byte2) produces no write.
- rd_data is combinational. If a fabric read and a bus write hit the same address in the same cycle, rd_data shows the old value and the new value appears the next cycle.
- Timing requirement: correct operation for SCL up to 400 kHz with clk_50m = 50 MHz. FILT_LEN+2 cycles of input latency must stay below the SCL low time.

Test Plan:
- Bus master sends START, 0x34, 0x00, 0x1F, STOP -> 3 ACKs seen. wr_stb pulses once with wr_addr=0x00, wr_data=0x01F. rd_addr=0 gives rd_data=0x01F. busy falls after STOP.
- Full codec sequence of 10 frames (0x34 00 1F … 0x34 12 01) -> regs 0..9 read 0x01F,0x01F,0x079,0x079,0x0F8,0x006,0x000,0x001,0x002,0x001. Exactly 10 wr_stb pulses.
- Address 0x36, then address 0x35 (read) -> no ACK on either (iic_sda_oe stays 0 throughout), no wr_stb, regfile unchanged.
- Frame 0x34, 0x20, 0x55 (reg 0x10 >= NUM_REGS) -> byte1 NACKed, byte2 ignored, no write.
- Truncation: 0x34, 0x02 then STOP; then 0x34, 0x02, then repeated START mid-byte2 followed by a valid 0x34 04 79 -> only reg2=0x079 is written, with a single wr_stb.
- Back-to-back pairs 0x34, 0x0C, 0x00, 0x0E, 0x01, STOP -> reg6=0x000, reg7=0x001, two wr_stb pulses. Assert rst during byte2 of a further frame -> iic_sda_oe=0 at once and all regs read 0.
